// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor: slice width,
// default slice count and the controller state encoding.
package nibble_serial_addsub_pkg;

    localparam int NIBBLE_W        = 4;
    localparam int NIBBLES_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_addsub_slice.sv
// One 4-bit add/subtract slice; subtraction inverts b and relies on the
// caller seeding the carry chain with 1.
module nibble_addsub_slice
    import nibble_serial_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    input  logic                i_m,
    input  logic                i_cin,
    output logic [NIBBLE_W-1:0] o_sum,
    output logic                o_cout,
    output logic                o_c3
);

    logic [NIBBLE_W-1:0] w_b_eff;
    logic [NIBBLE_W:0]   w_full;
    logic [NIBBLE_W-1:0] w_low;

    assign w_b_eff = i_b ^ {NIBBLE_W{i_m}};
    assign w_full  = {1'b0, i_a} + {1'b0, w_b_eff} + {{NIBBLE_W{1'b0}}, i_cin};
    // Carry into the top bit, needed for signed overflow on the last slice.
    assign w_low   = {1'b0, i_a[NIBBLE_W-2:0]} + {1'b0, w_b_eff[NIBBLE_W-2:0]}
                   + {{(NIBBLE_W-1){1'b0}}, i_cin};

    assign o_sum  = w_full[NIBBLE_W-1:0];
    assign o_cout = w_full[NIBBLE_W];
    assign o_c3   = w_low[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_addsub.sv
// Nibble-serial add/subtract: one 4-bit slice per cycle, LSB nibble first,
// result held with a valid/ready handshake.
//   state   | meaning
//   IDLE    | waiting for an operation, in_ready high
//   RUN     | processing slice r_idx
//   DONE    | result valid, waiting for out_ready
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter  int NIBBLES = NIBBLES_DEFAULT,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         m,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         v,
    output logic         zero,
    output logic         busy
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [W-1:0]        r_a;
    logic [W-1:0]        r_b;
    logic [W-1:0]        r_sum;
    logic                r_m;
    logic                r_carry;
    logic                r_cout;
    logic                r_v;
    logic                r_zero;
    logic [IDX_W-1:0]    r_idx;

    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_slice_sum;
    logic                w_slice_cout;
    logic                w_slice_c3;
    logic [W-1:0]        w_sum_next;
    logic                w_accept;
    logic                w_last;

    assign in_ready  = (r_state == ST_IDLE) && rst_n;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == LAST_IDX);

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_a_nib = r_a[k*NIBBLE_W +: NIBBLE_W];
                w_b_nib = r_b[k*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_addsub_slice u_slice (
        .i_a    (w_a_nib),
        .i_b    (w_b_nib),
        .i_m    (r_m),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout),
        .o_c3   (w_slice_c3)
    );

    // Full-width view including the slice being written, so zero covers all nibbles.
    always_comb begin
        w_sum_next = r_sum;
        for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sum_next[k*NIBBLE_W +: NIBBLE_W] = w_slice_sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)  w_state_next = ST_RUN;
            ST_RUN:  if (w_last)    w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default:                w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_v     <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_m     <= m;
                        r_idx   <= '0;
                        r_carry <= m;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_v     <= 1'b0;
                        r_zero  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_slice_cout;
                    if (w_last) begin
                        r_cout <= w_slice_cout;
                        r_v    <= w_slice_cout ^ w_slice_c3;
                        r_zero <= (w_sum_next == '0);
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign v         = r_v;
    assign zero      = r_zero;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Randomised and directed bench for nibble_serial_addsub against an
// arithmetic reference model.
module tb_nibble_serial_addsub;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         m_in      = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a_in      = '0;
    logic [W-1:0] b_in      = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         v;
    logic         zero;
    logic         busy;

    always #5 clk = ~clk;

    nibble_serial_addsub #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_in),
        .b         (b_in),
        .m         (m_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .v         (v),
        .zero      (zero),
        .busy      (busy)
    );

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         v;
        logic         zero;
    } res_t;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Plain integer arithmetic: modulo-2^W result, unsigned carry/no-borrow,
    // signed overflow from the exact signed result.
    function automatic res_t model_calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
        res_t   r;
        longint sx, sy, exact, lim;
        logic [W:0] wide;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        lim = longint'(1) <<< (W - 1);
        if (sub) begin
            r.sum  = x - y;
            r.cout = (x >= y);
            exact  = sx - sy;
        end else begin
            wide   = {1'b0, x} + {1'b0, y};
            r.sum  = wide[W-1:0];
            r.cout = wide[W];
            exact  = sx + sy;
        end
        r.v    = (exact >= lim) || (exact < -lim);
        r.zero = (r.sum == '0);
        return r;
    endfunction

    bit   m_known  = 1'b0;
    bit   m_active = 1'b0;
    int   m_cnt    = 0;
    res_t m_exp;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_known  = 1'b1;
            m_active = 1'b0;
            m_cnt    = 0;
        end else if (m_active) begin
            if (m_cnt >= NIBBLES && out_ready) m_active = 1'b0;
            else m_cnt++;
        end else if (in_valid) begin
            m_active = 1'b1;
            m_cnt    = 0;
            m_exp    = model_calc(a_in, b_in, m_in);
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            bit exp_ov;
            exp_ov = m_active && (m_cnt >= NIBBLES);
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("in_ready",  32'(in_ready),  32'(!m_active && rst_n));
            check("busy",      32'(busy),      32'(m_active));
            if (exp_ov) begin
                check("sum",  32'(sum),  32'(m_exp.sum));
                check("cout", 32'(cout), 32'(m_exp.cout));
                check("v",    32'(v),    32'(m_exp.v));
                check("zero", 32'(zero), 32'(m_exp.zero));
            end
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub,
                         input int hold, input bit noise, input bit lit,
                         input logic [W-1:0] l_sum, input logic l_cout, input logic l_v, input logic l_zero);
        int guard;
        int lat;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("wait_in_ready", 32'(in_ready), 32'd1);
            return;
        end
        a_in     = x;
        b_in     = y;
        m_in     = sub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a_in     = W'($urandom);
        b_in     = W'($urandom);
        m_in     = 1'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        check("latency", 32'(lat), 32'(NIBBLES));
        if (lit) begin
            check("lit_sum",    32'(sum),        32'(l_sum));
            check("lit_cout",   32'(cout),       32'(l_cout));
            check("lit_v",      32'(v),          32'(l_v));
            check("lit_zero",   32'(zero),       32'(l_zero));
            check("model_sum",  32'(m_exp.sum),  32'(l_sum));
            check("model_cout", 32'(m_exp.cout), 32'(l_cout));
            check("model_v",    32'(m_exp.v),    32'(l_v));
        end
        for (int i = 0; i < hold; i++) begin
            if (noise) begin
                in_valid = 1'($urandom);
                a_in     = W'($urandom);
                b_in     = W'($urandom);
                m_in     = 1'($urandom);
            end
            @(negedge clk);
        end
        check("held_out_valid", 32'(out_valid), 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("ready_after_hs", 32'(in_ready),  32'd1);
        check("ov_after_hs",    32'(out_valid), 32'd0);
    endtask

    logic [W-1:0] specials [4] = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before timeout");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] x, y;
        bit           saw_ov;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sum",  32'(sum),       32'd0);
        check("rst_cout", 32'(cout),      32'd0);
        check("rst_v",    32'(v),         32'd0);
        check("rst_zero", 32'(zero),      32'd0);
        check("rst_ov",   32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd1);

        do_op(16'h1234, 16'h0FFF, 1'b0, 0,  1'b0, 1'b1, 16'h2233, 1'b0, 1'b0, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1,  1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        do_op(16'hFFFF, 16'h0001, 1'b0, 0,  1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        do_op(16'h0005, 16'h0007, 1'b1, 2,  1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 0,  1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        do_op(16'h1234, 16'h0FFF, 1'b0, 10, 1'b1, 1'b1, 16'h2233, 1'b0, 1'b0, 1'b0);

        // Abort mid-operation while slice 2 is being processed.
        @(negedge clk);
        a_in = 16'h1234; b_in = 16'h1111; m_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(in_ready), 32'd1);
        saw_ov = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) saw_ov = 1'b1;
            @(negedge clk);
        end
        check("abort_no_ov", 32'(saw_ov), 32'd0);
        do_op(16'h0001, 16'h0001, 1'b1, 0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : W'($urandom);
            y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : W'($urandom);
            do_op(x, y, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                  1'b0, '0, 1'b0, 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
